// File: rtl/nufb_pkg.sv
// Shared types, default sizes and pointer helpers for the non-uniform filterbank.
package nufb_pkg;

    typedef logic signed [13:0] sample_t;

    localparam int NUFB_DEPTH  = 119;
    localparam int NUFB_PHASES = 60;

    // Advance a circular-buffer pointer by one slot, wrapping at depth.
    function automatic int nufb_ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    // Slot holding tap k (0 = newest) given the next write slot.
    // Computes (wr_ptr-1-k) mod depth with one conditional subtract, no divider.
    // Caller guarantees k < depth and wr_ptr < depth.
    function automatic int nufb_tap_addr(input int wr_ptr, input int k, input int depth);
        int s;
        s = wr_ptr + depth - 1 - k;
        return (s >= depth) ? s - depth : s;
    endfunction

endpackage

// File: rtl/nufb_phase_ctr.sv
// Phase counter that sequences the serial MAC filters; frame_strobe marks the last phase.
module nufb_phase_ctr
    import nufb_pkg::*;
#(
    parameter  int PHASES = NUFB_PHASES,
    localparam int PH_W   = $clog2(PHASES)
) (
    input  logic            clk_en,
    input  logic            reset,
    input  logic            enable,
    output logic [PH_W-1:0] phase,
    output logic            frame_strobe
);

    localparam logic [PH_W-1:0] LAST = PH_W'(PHASES - 1);

    // Count 0..PHASES-1 while enabled, hold otherwise.
    always_ff @(posedge clk_en) begin
        if (reset)
            phase <= '0;
        else if (enable)
            phase <= (phase == LAST) ? '0 : phase + PH_W'(1);
    end

    assign frame_strobe = (phase == LAST);

endmodule

// File: rtl/nufb_tap_buffer.sv
// Sample delay line with one-entry input holding register, commit sequencing
// and a registered symmetric tap-pair read port for linear-phase folding.
module nufb_tap_buffer
    import nufb_pkg::*;
#(
    parameter  int DATA_W = $bits(sample_t),
    parameter  int DEPTH  = NUFB_DEPTH,
    parameter  int PHASES = NUFB_PHASES,
    localparam int PH_W   = $clog2(PHASES),
    localparam int TAP_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_en,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PH_W-1:0]   phase,
    output logic              frame_strobe,
    input  logic              rd_en,
    input  logic [TAP_W-1:0]  rd_tap,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              primed,
    output logic              underrun,
    input  logic              clr_err
);

    // Storage is deliberately unreset; fill masks never-written slots.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [TAP_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fill;
    logic              hold_full;
    logic [DATA_W-1:0] hold_data;

    logic              commit;
    logic              accept;
    logic              new_underrun;
    logic [DATA_W-1:0] wr_data;

    logic              tap_ok;
    logic [TAP_W-1:0]  tap_b;
    logic [TAP_W-1:0]  addr_a;
    logic [TAP_W-1:0]  addr_b;
    logic              a_live;
    logic              b_live;

    nufb_phase_ctr #(.PHASES(PHASES)) u_phase_ctr (
        .clk_en       (clk_en),
        .reset        (reset),
        .enable       (enable),
        .phase        (phase),
        .frame_strobe (frame_strobe)
    );

    assign commit   = frame_strobe & enable;
    assign in_ready = ~hold_full | commit;
    assign accept   = in_valid & in_ready;
    assign primed   = (fill == CNT_W'(DEPTH));

    // Commit source priority: held sample, then bypassed input, else zero + underrun.
    always_comb begin
        wr_data      = '0;
        new_underrun = 1'b0;
        if (hold_full)
            wr_data = hold_data;
        else if (in_valid)
            wr_data = in_data;
        else
            new_underrun = commit;
    end

    // Holding register: refills on commit if it was full, loads on off-commit accepts.
    always_ff @(posedge clk_en) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (commit) begin
            if (hold_full) begin
                hold_full <= in_valid;
                if (in_valid)
                    hold_data <= in_data;
            end
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= in_data;
        end
    end

    // Write pointer and saturating fill count advance once per commit.
    always_ff @(posedge clk_en) begin
        if (reset) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (commit) begin
            wr_ptr <= TAP_W'(nufb_ptr_inc(int'(wr_ptr), DEPTH));
            if (fill != CNT_W'(DEPTH))
                fill <= fill + CNT_W'(1);
        end
    end

    // Sticky underrun; a fresh underrun beats a same-cycle clear.
    always_ff @(posedge clk_en) begin
        if (reset)
            underrun <= 1'b0;
        else if (new_underrun)
            underrun <= 1'b1;
        else if (clr_err)
            underrun <= 1'b0;
    end

    // Sample memory write; reads in the same cycle still see the old contents.
    always_ff @(posedge clk_en) begin
        if (commit && !reset)
            mem[wr_ptr] <= wr_data;
    end

    // Tap pair address decode; out-of-range taps are parked at slot 0 and masked.
    always_comb begin
        tap_ok = (CNT_W'(rd_tap) < CNT_W'(DEPTH));
        tap_b  = TAP_W'(DEPTH - 1) - rd_tap;
        addr_a = '0;
        addr_b = '0;
        if (tap_ok) begin
            addr_a = TAP_W'(nufb_tap_addr(int'(wr_ptr), int'(rd_tap), DEPTH));
            addr_b = TAP_W'(nufb_tap_addr(int'(wr_ptr), int'(tap_b), DEPTH));
        end
        a_live = tap_ok && (CNT_W'(rd_tap) < fill);
        b_live = tap_ok && (CNT_W'(tap_b) < fill);
    end

    // Registered read port: one request per cycle, one cycle latency.
    always_ff @(posedge clk_en) begin
        if (reset) begin
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_valid  <= rd_en;
            rd_err    <= rd_en & ~tap_ok;
            rd_data_a <= (rd_en && a_live) ? mem[addr_a] : '0;
            rd_data_b <= (rd_en && b_live) ? mem[addr_b] : '0;
        end
    end

endmodule

// File: tb/tb_nufb_tap_buffer.sv
// Randomised scoreboard bench: history-queue model of committed samples,
// expected read results queued at issue and checked by a separate monitor.
module tb_nufb_tap_buffer;

    localparam int DATA_W = 14;
    localparam int DEPTH  = 13;
    localparam int PHASES = 4;
    localparam int PH_W   = $clog2(PHASES);
    localparam int TAP_W  = $clog2(DEPTH);

    logic              clk_en = 1'b0;
    logic              reset, enable, in_valid, rd_en, clr_err;
    logic [DATA_W-1:0] in_data;
    logic [TAP_W-1:0]  rd_tap;
    logic              in_ready, frame_strobe, rd_valid, rd_err, primed, underrun;
    logic [PH_W-1:0]   phase;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;

    nufb_tap_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PHASES(PHASES)) dut (
        .clk_en(clk_en), .reset(reset), .enable(enable),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .phase(phase), .frame_strobe(frame_strobe),
        .rd_en(rd_en), .rd_tap(rd_tap), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_valid(rd_valid), .rd_err(rd_err), .primed(primed),
        .underrun(underrun), .clr_err(clr_err)
    );

    always #5 clk_en = ~clk_en;

    typedef struct {
        bit                vld;
        bit                err;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } rd_exp_t;

    rd_exp_t           exp_q[$];
    logic [DATA_W-1:0] hist[$];   // committed samples, newest at index 0, at most DEPTH
    logic [DATA_W-1:0] pend[$];   // accepted but not yet committed samples
    int                m_phase;
    bit                m_under;
    bit                m_known = 1'b0;
    int                checks = 0;
    int                failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] tapval(input int k);
        return (k < hist.size()) ? hist[k] : '0;
    endfunction

    // One clock of stimulus: drive, check pre-edge state, queue read expectation, advance model.
    task automatic step(input bit rst, input bit en, input bit iv, input logic [DATA_W-1:0] d,
                        input bit re, input int tap, input bit clr);
        rd_exp_t           e;
        bit                com, rdy, acc, nu;
        logic [DATA_W-1:0] w;
        @(negedge clk_en);
        reset = rst; enable = en; in_valid = iv; in_data = d;
        rd_en = re; rd_tap = TAP_W'(tap); clr_err = clr;
        #1;
        com = en && (m_phase == PHASES - 1);
        rdy = (pend.size() == 0) || com;
        if (m_known) begin
            chk("phase", 32'(phase), 32'(m_phase));
            chk("frame_strobe", 32'(frame_strobe), 32'(m_phase == PHASES - 1));
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("primed", 32'(primed), 32'(hist.size() == DEPTH));
            chk("underrun", 32'(underrun), 32'(m_under));
        end
        e.vld = !rst && re;
        e.err = e.vld && (tap >= DEPTH);
        e.a   = (e.vld && tap < DEPTH) ? tapval(tap) : '0;
        e.b   = (e.vld && tap < DEPTH) ? tapval(DEPTH - 1 - tap) : '0;
        exp_q.push_back(e);
        if (rst) begin
            m_phase = 0; m_under = 0; m_known = 1;
            hist.delete(); pend.delete();
        end else begin
            acc = iv && rdy;
            nu  = 0;
            if (com) begin
                if (pend.size() > 0) begin
                    w = pend.pop_front();
                    if (acc) pend.push_back(d);
                end else if (iv) begin
                    w = d;
                end else begin
                    w = '0; nu = 1;
                end
                hist.push_front(w);
                if (hist.size() > DEPTH) void'(hist.pop_back());
            end else if (acc) begin
                pend.push_back(d);
            end
            if (nu) m_under = 1;
            else if (clr) m_under = 0;
            if (en) m_phase = (m_phase + 1) % PHASES;
        end
    endtask

    // Monitor: every cycle the DUT's read port is compared with the oldest expectation.
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge clk_en);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_valid", 32'(rd_valid), 32'(e.vld));
                if (e.vld) begin
                    chk("rd_err", 32'(rd_err), 32'(e.err));
                    chk("rd_data_a", 32'(rd_data_a), 32'(e.a));
                    chk("rd_data_b", 32'(rd_data_b), 32'(e.b));
                end
            end
        end
    end

    initial begin
        reset = 1; enable = 0; in_valid = 0; in_data = '0;
        rd_en = 0; rd_tap = '0; clr_err = 0;
        // reset with a read request pending: the read must be dropped
        step(1, 0, 0, '0, 1, 0, 0);
        step(1, 1, 1, 14'd7, 1, 2, 0);
        // one sample per frame, values 1,2,3..., random tap reads every cycle
        for (int c = 0; c < 20 * PHASES; c++)
            step(0, 1, m_phase == 0, DATA_W'(c / PHASES + 1), 1, int'($urandom_range(0, 15)), 0);
        // frozen sequencer, sweep every tap including out-of-range ones
        for (int t = 0; t < 16; t++)
            step(0, 0, 0, '0, 1, t, 0);
        // starve two frames, then clear the sticky flag
        for (int c = 0; c < 2 * PHASES; c++)
            step(0, 1, 0, '0, 1, 0, 0);
        step(0, 0, 0, '0, 0, 0, 1);
        // back-to-back samples: second waits in holding until the commit cycle
        for (int c = 0; c < 4 * PHASES; c++)
            step(0, 1, 1, DATA_W'(100 + c), 1, int'($urandom_range(0, 15)), 0);
        // randomised traffic, signed data, enable gaps and error clears
        for (int c = 0; c < 3000; c++)
            step(0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, DATA_W'($urandom),
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
        // reset mid-operation with a read in flight, then resume
        step(1, 1, 1, 14'd5, 1, 3, 0);
        for (int c = 0; c < 200; c++)
            step(0, 1, $urandom_range(0, 1) == 0, DATA_W'($urandom),
                 $urandom_range(0, 1) == 0, int'($urandom_range(0, 15)), 0);
        step(0, 0, 0, '0, 0, 0, 0);
        @(posedge clk_en);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
